// File: rtl/tilt_pkg.sv
// tilt_pkg: shared types and constants for the tilt filter.
//   - tilt_state_e : sequencing FSM states
//   - DIR_*        : bit positions inside tilt_dir
//   - step_t       : signed step value at the default step width
//   - dir_from_steps : packs per-axis sign flags into a tilt_dir vector
package tilt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2,
    EMIT  = 2'd3
  } tilt_state_e;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  localparam int STEP_W_DEF = 4;
  typedef logic signed [STEP_W_DEF-1:0] step_t;

  function automatic logic [3:0] dir_from_steps(input logic x_pos, input logic x_neg,
                                                input logic y_pos, input logic y_neg);
    logic [3:0] d;
    d            = '0;
    d[DIR_UP]    = y_pos;
    d[DIR_DOWN]  = y_neg;
    d[DIR_LEFT]  = x_neg;
    d[DIR_RIGHT] = x_pos;
    return d;
  endfunction

endpackage

// File: rtl/tilt_axis.sv
// tilt_axis: one accelerometer axis of the tilt filter.
// Holds the 2^AVG_LOG2 sample history, the running sum, and the
// average -> deadzone -> shift -> clamp path that yields a signed step.
// Optional build macro TILT_CAL_EN adds a latched zero offset.
// Ports:
//   clk, reset_n   : clock, async active-low reset
//   flush_i        : clear running sum
//   accum_en_i     : add sample_i to the window (ACCUM cycle)
//   step_en_i      : register a new step (SCALE cycle with full window)
//   cal_latch_i    : latch current average as offset (TILT_CAL_EN only)
//   full_i         : window was full before this accumulate
//   ptr_i          : history slot to read (oldest) and overwrite
//   sample_i       : registered new sample
//   step_o         : registered signed step
module tilt_axis
  import tilt_pkg::*;
#(
  parameter int AVG_LOG2   = 2,
  parameter int DEADZONE   = 16,
  parameter int STEP_SHIFT = 4,
  parameter int MAX_STEP   = 7,
  parameter int STEP_W     = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush_i,
  input  logic                     accum_en_i,
  input  logic                     step_en_i,
`ifdef TILT_CAL_EN
  input  logic                     cal_latch_i,
`endif
  input  logic                     full_i,
  input  logic [AVG_LOG2-1:0]      ptr_i,
  input  logic signed [15:0]       sample_i,
  output logic signed [STEP_W-1:0] step_o
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = 16 + AVG_LOG2;

  logic signed [15:0]       hist_q [DEPTH];
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic signed [15:0]       oldest;
  logic signed [15:0]       avg;
  logic signed [15:0]       adj;
  logic        [16:0]       adj_ext;
  logic        [16:0]       mag;
  logic        [16:0]       excess;
  logic signed [STEP_W-1:0] mag_step;
  logic signed [STEP_W-1:0] step_q, step_d;

  // History RAM is never reset; full_i keeps stale entries out of the sum.
  always_ff @(posedge clk) begin
    if (accum_en_i) hist_q[ptr_i] <= sample_i;
  end

  // When full, ptr_i addresses the oldest sample, which is retired here.
  assign oldest = full_i ? hist_q[ptr_i] : '0;
  assign sum_d  = sum_q + SUM_W'(sample_i) - SUM_W'(oldest);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        sum_q <= '0;
    else if (flush_i)    sum_q <= '0;
    else if (accum_en_i) sum_q <= sum_d;
  end

  // Arithmetic shift floors toward -inf; the quotient always fits 16 bits.
  assign avg = 16'(sum_q >>> AVG_LOG2);

`ifdef TILT_CAL_EN
  logic signed [15:0] offset_q;
  logic signed [16:0] diff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         offset_q <= '0;
    else if (cal_latch_i) offset_q <= avg;
  end

  assign diff = 17'(avg) - 17'(offset_q);
  // Saturate back to 16 bits when the two top bits disagree.
  assign adj  = (diff[16] != diff[15]) ? (diff[16] ? 16'sh8000 : 16'sh7fff)
                                       : diff[15:0];
`else
  assign adj = avg;
`endif

  // 17-bit magnitude so that -32768 maps to +32768.
  assign adj_ext = {adj[15], adj};
  assign mag     = adj[15] ? (~adj_ext + 17'd1) : adj_ext;

  always_comb begin
    excess   = '0;
    mag_step = '0;
    step_d   = '0;
    if (mag > 17'(DEADZONE)) begin
      excess   = (mag - 17'(DEADZONE)) >> STEP_SHIFT;
      mag_step = (excess > 17'(MAX_STEP)) ? STEP_W'(MAX_STEP) : STEP_W'(excess);
      step_d   = adj[15] ? -mag_step : mag_step;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       step_q <= '0;
    else if (step_en_i) step_q <= step_d;
  end

  assign step_o = step_q;

endmodule

// File: rtl/tilt_filter.sv
// tilt_filter: turns accelerometer X/Y updates into signed per-axis step
// values with a one-cycle step_valid strobe for the maze movement logic.
// Optional build macro TILT_CAL_EN: the first full-window average is taken
// as a zero offset (no strobe), later averages are offset-corrected.
// Ports:
//   clk, reset_n        : clock, async active-low reset
//   data_update         : one-cycle new-sample strobe
//   data_x, data_y      : signed 16-bit samples
//   flush               : synchronous clear of filter history
//   step_valid          : one-cycle strobe, steps/tilt_dir valid
//   step_x, step_y      : signed steps, held between strobes
//   tilt_dir            : {up, down, left, right}
//   overrun             : one-cycle pulse, update dropped while busy
//
// state | meaning
// IDLE  | waiting for data_update, sample registered on accept
// ACCUM | update running sums, history, pointer and fill count
// SCALE | average, deadzone, clamp; register steps
// EMIT  | schedule step_valid if the window was full
module tilt_filter
  import tilt_pkg::*;
#(
  parameter int AVG_LOG2   = 2,
  parameter int DEADZONE   = 16,
  parameter int STEP_SHIFT = 4,
  parameter int MAX_STEP   = 7,
  parameter int STEP_W     = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     data_update,
  input  logic [15:0]              data_x,
  input  logic [15:0]              data_y,
  input  logic                     flush,
  output logic                     step_valid,
  output logic signed [STEP_W-1:0] step_x,
  output logic signed [STEP_W-1:0] step_y,
  output logic [3:0]               tilt_dir,
  output logic                     overrun
);

  localparam int FILL_W = AVG_LOG2 + 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(1 << AVG_LOG2);

  tilt_state_e          state_q, state_d;
  logic [AVG_LOG2-1:0]  ptr_q, ptr_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic signed [15:0]   smp_x_q, smp_x_d;
  logic signed [15:0]   smp_y_q, smp_y_d;
  logic                 step_valid_q, step_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 emit_q, emit_d;
  logic                 full;
  logic                 accum_en;
  logic                 scale_en;
  logic                 step_en;

  assign full     = (fill_q == FILL_MAX);
  assign accum_en = (state_q == ACCUM) && !flush;
  assign scale_en = (state_q == SCALE) && !flush;

`ifdef TILT_CAL_EN
  logic cal_done_q, cal_done_d;
  logic cal_latch;

  assign step_en   = scale_en && full && cal_done_q;
  assign cal_latch = scale_en && full && !cal_done_q;
`else
  assign step_en   = scale_en && full;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      fill_q       <= '0;
      smp_x_q      <= '0;
      smp_y_q      <= '0;
      step_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      emit_q       <= 1'b0;
`ifdef TILT_CAL_EN
      cal_done_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      fill_q       <= fill_d;
      smp_x_q      <= smp_x_d;
      smp_y_q      <= smp_y_d;
      step_valid_q <= step_valid_d;
      overrun_q    <= overrun_d;
      emit_q       <= emit_d;
`ifdef TILT_CAL_EN
      cal_done_q   <= cal_done_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    fill_d       = fill_q;
    smp_x_d      = smp_x_q;
    smp_y_d      = smp_y_q;
    step_valid_d = 1'b0;
    overrun_d    = 1'b0;
    emit_d       = emit_q;
`ifdef TILT_CAL_EN
    cal_done_d   = cal_done_q;
`endif
    if (flush) begin
      // A coincident data_update is discarded silently.
      state_d    = IDLE;
      ptr_d      = '0;
      fill_d     = '0;
      emit_d     = 1'b0;
`ifdef TILT_CAL_EN
      cal_done_d = 1'b0;
`endif
    end else begin
      if (data_update && (state_q != IDLE)) overrun_d = 1'b1;
      case (state_q)
        IDLE: begin
          if (data_update) begin
            smp_x_d = data_x;
            smp_y_d = data_y;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          ptr_d   = ptr_q + AVG_LOG2'(1);
          if (!full) fill_d = fill_q + FILL_W'(1);
          state_d = SCALE;
        end
        SCALE: begin
`ifdef TILT_CAL_EN
          emit_d = full && cal_done_q;
          if (full) cal_done_d = 1'b1;
`else
          emit_d = full;
`endif
          state_d = EMIT;
        end
        EMIT: begin
          // Strobe is registered, so it appears in the cycle after EMIT.
          step_valid_d = emit_q;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  tilt_axis #(
    .AVG_LOG2  (AVG_LOG2),
    .DEADZONE  (DEADZONE),
    .STEP_SHIFT(STEP_SHIFT),
    .MAX_STEP  (MAX_STEP),
    .STEP_W    (STEP_W)
  ) u_axis_x (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush_i    (flush),
    .accum_en_i (accum_en),
    .step_en_i  (step_en),
`ifdef TILT_CAL_EN
    .cal_latch_i(cal_latch),
`endif
    .full_i     (full),
    .ptr_i      (ptr_q),
    .sample_i   (smp_x_q),
    .step_o     (step_x)
  );

  tilt_axis #(
    .AVG_LOG2  (AVG_LOG2),
    .DEADZONE  (DEADZONE),
    .STEP_SHIFT(STEP_SHIFT),
    .MAX_STEP  (MAX_STEP),
    .STEP_W    (STEP_W)
  ) u_axis_y (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush_i    (flush),
    .accum_en_i (accum_en),
    .step_en_i  (step_en),
`ifdef TILT_CAL_EN
    .cal_latch_i(cal_latch),
`endif
    .full_i     (full),
    .ptr_i      (ptr_q),
    .sample_i   (smp_y_q),
    .step_o     (step_y)
  );

  assign tilt_dir = dir_from_steps(!step_x[STEP_W-1] && (step_x != '0),
                                   step_x[STEP_W-1],
                                   !step_y[STEP_W-1] && (step_y != '0),
                                   step_y[STEP_W-1]);

  assign step_valid = step_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_tilt_filter.sv
module tb_tilt_filter;
  import tilt_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        data_update;
  logic [15:0] data_x;
  logic [15:0] data_y;
  logic        flush;
  logic        step_valid;
  step_t       step_x;
  step_t       step_y;
  logic [3:0]  tilt_dir;
  logic        overrun;

  int err_cnt;
  int chk_cnt;
  int hx, hy, hd;

  tilt_filter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_update(data_update),
    .data_x     (data_x),
    .data_y     (data_y),
    .flush      (flush),
    .step_valid (step_valid),
    .step_x     (step_x),
    .step_y     (step_y),
    .tilt_dir   (tilt_dir),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    chk_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int sx, input int sy, input int dir);
    check_eq({tag, ".x"},   int'(step_x), sx);
    check_eq({tag, ".y"},   int'(step_y), sy);
    check_eq({tag, ".dir"}, int'(tilt_dir), dir);
  endtask

  // One accepted update; watches 4 cycles for the strobe and any overrun.
  task automatic upd(input string tag, input int x, input int y, input bit vld,
                     input int sx, input int sy, input int dir);
    int seen, at, ov;
    seen = 0; at = 0; ov = 0;
    data_x = 16'(x);
    data_y = 16'(y);
    data_update = 1'b1;
    @(posedge clk); #1;
    data_update = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (step_valid) begin seen++; at = c; end
      if (overrun) ov++;
    end
    if (vld) begin hx = sx; hy = sy; hd = dir; end
    check_eq({tag, ".strobe"}, seen, vld ? 1 : 0);
    if (vld) check_eq({tag, ".lat"}, at, 3);
    check_outs(tag, hx, hy, hd);
    check_eq({tag, ".ovr"}, ov, 0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    err_cnt = 0; chk_cnt = 0;
    hx = 0; hy = 0; hd = 0;
    reset_n = 1'b0; data_update = 1'b0; flush = 1'b0;
    data_x = '0; data_y = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.valid", int'(step_valid), 0);
    check_eq("rst.ovr",   int'(overrun), 0);
    check_outs("rst", 0, 0, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

`ifdef TILT_CAL_EN
    for (int i = 0; i < 4; i++) upd("cal1", 40, 0, 0, 0, 0, 0);
    upd("cal_a", 140, 0, 1, 0, 0, 0);
    upd("cal_b", 140, 0, 1, 2, 0, 1);
    upd("cal_c", 140, 0, 1, 3, 0, 1);
    upd("cal_d", 140, 0, 1, 5, 0, 1);
    // reset while the next sample is in ACCUM
    data_x = 16'(140); data_y = '0; data_update = 1'b1;
    @(posedge clk); #1;
    data_update = 1'b0;
    reset_n = 1'b0;
    #1;
    check_eq("mrst.valid", int'(step_valid), 0);
    check_eq("mrst.ovr",   int'(overrun), 0);
    check_outs("mrst", 0, 0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    hx = 0; hy = 0; hd = 0;
    for (int i = 0; i < 4; i++) upd("cal2", 40, 0, 0, 0, 0, 0);
    upd("cal2_a", 140, 0, 1, 0, 0, 0);
`else
    // warm-up
    for (int i = 0; i < 3; i++) upd("warm", 100, 0, 0, 0, 0, 0);
    upd("warm4", 100, 0, 1, 5, 0, 4'b0001);
    // window slide
    upd("slide1", -100, 0, 1,  2, 0, 4'b0001);
    upd("slide2", -100, 0, 1,  0, 0, 4'b0000);
    upd("slide3", -100, 0, 1, -2, 0, 4'b0010);
    upd("slide4", -100, 0, 1, -5, 0, 4'b0010);
    // deadzone and clamp
    upd("dz1", 10, -300, 1, -3, -3, 4'b0110);
    upd("dz2", 10, -300, 1, -1, -7, 4'b0110);
    upd("dz3", 10, -300, 1,  0, -7, 4'b0100);
    upd("dz4", 10, -300, 1,  0, -7, 4'b0100);
    for (int i = 0; i < 4; i++) upd("pmax", 10, 32767, 1, 0, 7, 4'b1000);
    upd("nmin1", 10, -32768, 1, 0,  7, 4'b1000);
    upd("nmin2", 10, -32768, 1, 0,  0, 4'b0000);
    upd("nmin3", 10, -32768, 1, 0, -7, 4'b0100);
    upd("nmin4", 10, -32768, 1, 0, -7, 4'b0100);
    // overrun: second update lands two cycles after the first
    do_flush();
    data_x = 16'(200); data_y = '0; data_update = 1'b1;
    @(posedge clk); #1;
    data_update = 1'b0;
    @(posedge clk); #1;
    data_x = 16'(-32768); data_y = 16'(-32768); data_update = 1'b1;
    @(posedge clk); #1;
    data_update = 1'b0;
    check_eq("ovr.pulse", int'(overrun), 1);
    @(posedge clk); #1;
    check_eq("ovr.single", int'(overrun), 0);
    check_eq("ovr.valid", int'(step_valid), 0);
    @(posedge clk); #1;
    upd("ovr_a", 200, 0, 0, 0, 0, 0);
    upd("ovr_b", 200, 0, 0, 0, 0, 0);
    upd("ovr_c", 200, 0, 1, 7, 0, 4'b0001);
    // flush with a simultaneous update after 3 fills
    do_flush();
    for (int i = 0; i < 3; i++) upd("pre_fl", 500, 500, 0, 0, 0, 0);
    data_x = 16'(1000); data_y = 16'(1000);
    flush = 1'b1; data_update = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; data_update = 1'b0;
    check_eq("fl.ovr0", int'(overrun), 0);
    check_eq("fl.valid", int'(step_valid), 0);
    @(posedge clk); #1;
    check_eq("fl.ovr1", int'(overrun), 0);
    check_outs("fl.hold", 7, 0, 4'b0001);
    for (int i = 0; i < 3; i++) upd("post_fl", 32, -16, 0, 0, 0, 0);
    upd("post_fl4", 32, -16, 1, 1, 0, 4'b0001);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
